ahb3lite_interconnect_slave_port: RTL and testbench

Per-slave arbitration and multiplexing stage of the AHB3-Lite multi-layer switch, directly downstream of the master ports. It collects the address-phase requests from all master ports aimed at one AHB slave. It grants the bus to one master by priority, with round-robin among equal priorities, and switches owner only at legal transfer boundaries. It drives the selected master's address/control and the data-phase master's write data onto the slave, and broadcasts the slave's response back to all master ports.

---
 rtl/ahb3lite_interconnect_slave_port.sv | 96 +++++++++
 tb/tb_ahb3lite_interconnect_slave_port.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_slave_port.sv
// ahb3lite_interconnect_slave_port: per-slave priority/round-robin arbiter and address/data mux
// Ports: mst* = per-master requests in and broadcast responses out; slv_* = muxed bus to the slave;
//        mstpriority/can_switch steer arbitration; master_granted is the registered one-hot owner.
module ahb3lite_interconnect_slave_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MASTERS    = 3
) (
  input  logic                                   HRESETn,
  input  logic                                   HCLK,
  input  logic [MASTERS-1:0][2:0]                mstpriority,
  input  logic [MASTERS-1:0]                     mstHSEL,
  input  logic [MASTERS-1:0][HADDR_SIZE-1:0]     mstHADDR,
  input  logic [MASTERS-1:0][HDATA_SIZE-1:0]     mstHWDATA,
  input  logic [MASTERS-1:0]                     mstHWRITE,
  input  logic [MASTERS-1:0][2:0]                mstHSIZE,
  input  logic [MASTERS-1:0][2:0]                mstHBURST,
  input  logic [MASTERS-1:0][3:0]                mstHPROT,
  input  logic [MASTERS-1:0][1:0]                mstHTRANS,
  input  logic [MASTERS-1:0]                     mstHMASTLOCK,
  input  logic [MASTERS-1:0]                     mstHREADY,
  input  logic [MASTERS-1:0]                     can_switch,
  output logic [MASTERS-1:0]                     master_granted,
  output logic [HDATA_SIZE-1:0]                  mstHRDATA,
  output logic                                   mstHREADYOUT,
  output logic                                   mstHRESP,
  output logic                                   slv_HSEL,
  output logic [HADDR_SIZE-1:0]                  slv_HADDR,
  output logic [HDATA_SIZE-1:0]                  slv_HWDATA,
  output logic                                   slv_HWRITE,
  output logic [2:0]                             slv_HSIZE,
  output logic [2:0]                             slv_HBURST,
  output logic [3:0]                             slv_HPROT,
  output logic [1:0]                             slv_HTRANS,
  output logic                                   slv_HMASTLOCK,
  output logic                                   slv_HREADY,
  input  logic [HDATA_SIZE-1:0]                  slv_HRDATA,
  input  logic                                   slv_HREADYOUT,
  input  logic                                   slv_HRESP
);
  localparam int IW = MASTERS > 1 ? $clog2(MASTERS) : 1;
  logic [MASTERS-1:0] owner_q, owner_d, req;
  logic [IW-1:0] oi, rr_q, rr_d, dp_q, dp_d, win, idx;
  logic [2:0] maxp;
  logic owned, locked, sw;
  always_comb begin
    oi = '0;
    for (int m = 0; m < MASTERS; m++) begin
      req[m] = mstHSEL[m] & (mstHTRANS[m] != 2'b00);
      if (owner_q[m]) oi = IW'(m);
    end
  end
  // Highest requesting priority, then the first master at that level after rr_q.
  // Scanning from the farthest candidate down lets the nearest one overwrite win.
  always_comb begin
    maxp = '0;
    for (int m = 0; m < MASTERS; m++)
      if (req[m] && mstpriority[m] > maxp) maxp = mstpriority[m];
    win = rr_q;
    idx = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      idx = IW'((int'(rr_q) + k) % MASTERS);
      if (req[idx] && mstpriority[idx] == maxp) win = idx;
    end
  end
  assign owned   = |owner_q;
  assign locked  = owned & mstHMASTLOCK[oi] & (mstHTRANS[oi] != 2'b00);
  assign sw      = slv_HREADYOUT & ~locked & (~owned | ~req[oi] | can_switch[oi]);
  assign owner_d = (sw & |req) ? MASTERS'(1) << win : owner_q;
  assign rr_d    = (sw & |req) ? win : rr_q;
  assign dp_d    = slv_HREADYOUT ? oi : dp_q;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      owner_q <= '0;
      rr_q    <= IW'(MASTERS - 1);
      dp_q    <= '0;
    end else begin
      owner_q <= owner_d;
      rr_q    <= rr_d;
      dp_q    <= dp_d;
    end
  assign master_granted = owner_q;
  assign slv_HSEL       = owned & mstHSEL[oi];
  assign slv_HADDR      = mstHADDR[oi];
  assign slv_HWRITE     = mstHWRITE[oi];
  assign slv_HSIZE      = mstHSIZE[oi];
  assign slv_HBURST     = mstHBURST[oi];
  assign slv_HPROT      = mstHPROT[oi];
  assign slv_HMASTLOCK  = mstHMASTLOCK[oi];
  assign slv_HTRANS     = owned ? mstHTRANS[oi] : 2'b00;
  assign slv_HREADY     = owned ? mstHREADY[oi] : 1'b1;
  assign slv_HWDATA     = mstHWDATA[dp_q];
  assign mstHRDATA      = slv_HRDATA;
  assign mstHREADYOUT   = slv_HREADYOUT;
  assign mstHRESP       = slv_HRESP;
endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// tb_ahb3lite_interconnect_slave_port: directed and random checks against a behavioural arbiter model
module tb_ahb3lite_interconnect_slave_port;
  localparam int M = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [M-1:0][2:0] pri, hsize, hburst;
  logic [M-1:0][3:0] hprot;
  logic [M-1:0][1:0] htrans;
  logic [M-1:0] hsel, hwrite, hlock, hready, cs, g;
  logic [M-1:0][31:0] haddr, hwdata;
  logic [31:0] mrdata, shaddr, shwdata, srdata;
  logic mreadyout, mresp, shsel, shwrite, shlock, shready, sreadyout, sresp;
  logic [2:0] shsize, shburst;
  logic [3:0] shprot;
  logic [1:0] shtrans;
  ahb3lite_interconnect_slave_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(M)) dut (
    .HRESETn(rst_n), .HCLK(clk), .mstpriority(pri), .mstHSEL(hsel), .mstHADDR(haddr),
    .mstHWDATA(hwdata), .mstHWRITE(hwrite), .mstHSIZE(hsize), .mstHBURST(hburst),
    .mstHPROT(hprot), .mstHTRANS(htrans), .mstHMASTLOCK(hlock), .mstHREADY(hready),
    .can_switch(cs), .master_granted(g), .mstHRDATA(mrdata), .mstHREADYOUT(mreadyout),
    .mstHRESP(mresp), .slv_HSEL(shsel), .slv_HADDR(shaddr), .slv_HWDATA(shwdata),
    .slv_HWRITE(shwrite), .slv_HSIZE(shsize), .slv_HBURST(shburst), .slv_HPROT(shprot),
    .slv_HTRANS(shtrans), .slv_HMASTLOCK(shlock), .slv_HREADY(shready),
    .slv_HRDATA(srdata), .slv_HREADYOUT(sreadyout), .slv_HRESP(sresp)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  function automatic bit rq(input int m);
    return hsel[m] && htrans[m] != 2'd0;
  endfunction
  // Model state: owner (-1 = none), last granted index, data-phase owner index.
  int m_owner, m_rr, m_dp;
  always @(negedge clk) begin
    int o, mp, w;
    bit any, ok;
    if (!rst_n) begin
      m_owner = -1; m_rr = M - 1; m_dp = 0;
      chk("rst_grant", g, 0);
      chk("rst_hsel", shsel, 0);
      chk("rst_htrans", shtrans, 0);
      chk("rst_hready", shready, 1);
    end else begin
      o = m_owner < 0 ? 0 : m_owner;
      chk("grant", g, m_owner < 0 ? 0 : (1 << m_owner));
      chk("hsel", shsel, m_owner >= 0 && hsel[o]);
      chk("htrans", shtrans, m_owner >= 0 ? htrans[o] : 2'd0);
      chk("haddr", shaddr, haddr[o]);
      chk("ctrl", {shwrite, shsize, shburst, shprot, shlock},
          {hwrite[o], hsize[o], hburst[o], hprot[o], hlock[o]});
      chk("hready", shready, m_owner >= 0 ? hready[o] : 1'b1);
      chk("hwdata", shwdata, hwdata[m_dp]);
      chk("resp", {mrdata, mreadyout, mresp}, {srdata, sreadyout, sresp});
      if (sreadyout) begin
        any = 0; mp = 0; w = -1;
        for (int m = 0; m < M; m++) if (rq(m)) begin any = 1; if (pri[m] > mp) mp = pri[m]; end
        for (int i = 1; i <= M; i++) if (w < 0 && rq((m_rr + i) % M) && pri[(m_rr + i) % M] == mp) w = (m_rr + i) % M;
        ok = m_owner < 0 || !rq(o) || cs[o];
        if (m_owner >= 0 && hlock[o] && htrans[o] != 2'd0) ok = 0;
        m_dp = o;
        if (ok && any) begin m_owner = w; m_rr = w; end
      end
    end
  end
  task automatic step;
    @(posedge clk); #1;
  endtask
  initial begin
    pri = '0; hsize = '0; hburst = '0; hprot = '0; htrans = '0; hsel = '0; hwrite = '0;
    hlock = '0; hready = '1; cs = '1; haddr = '0; hwdata = '0;
    srdata = 32'h1234_5678; sreadyout = 1; sresp = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) begin
      step;
      chk("idle_grant", g, 0); chk("idle_hsel", shsel, 0); chk("idle_htrans", shtrans, 0);
    end
    hsel = 3'b111; htrans = {3{2'd2}}; pri = {3{3'd3}};
    haddr[0] = 32'h100; haddr[1] = 32'h200; haddr[2] = 32'h300;
    step; chk("rr0", g, 3'b001);
    step; chk("rr1", g, 3'b010);
    step; chk("rr2", g, 3'b100);
    step; chk("rr3", g, 3'b001);
    pri[0] = 3'd1; pri[2] = 3'd5; hsel = 3'b101;
    step; chk("prio", g, 3'b100);
    hsel = 3'b010; pri[1] = 3'd3;
    step; chk("burst_own", g, 3'b010);
    htrans[1] = 2'd3; hburst[1] = 3'd3; cs[1] = 0; hsel = 3'b110;
    repeat (3) begin step; chk("burst_hold", g, 3'b010); end
    cs[1] = 1; sreadyout = 0;
    step; chk("burst_wait", g, 3'b010);
    sreadyout = 1;
    step; chk("burst_switch", g, 3'b100);
    hsel = 3'b001; htrans = {2'd2, 2'd2, 2'd2}; hwrite[0] = 1; pri = {3{3'd3}};
    hwdata[0] = 32'hA0; hwdata[1] = 32'hB1; hwdata[2] = 32'hC2;
    step; chk("ws_own0", g, 3'b001);
    hsel = 3'b011; hwrite[1] = 1;
    step; chk("ws_own1", g, 3'b010); chk("ws_wd0", shwdata, 32'hA0);
    sreadyout = 0;
    step; chk("ws_wd1", shwdata, 32'hA0); chk("ws_g1", g, 3'b010);
    step; chk("ws_wd2", shwdata, 32'hA0);
    sreadyout = 1;
    step; chk("ws_wd3", shwdata, 32'hB1); chk("ws_g3", g, 3'b001);
    hlock[0] = 1; pri[1] = 3'd7;
    step; chk("lock0", g, 3'b001);
    step; chk("lock1", g, 3'b001);
    htrans[0] = 2'd0;
    step; chk("lock_rel", g, 3'b010);
    hlock = '0;
    for (int i = 0; i < 400; i++) begin
      step;
      if (i == 201) rst_n = 1;
      for (int m = 0; m < M; m++) begin
        htrans[m] = 2'($urandom_range(0, 3)); pri[m] = 3'($urandom_range(0, 7));
        hlock[m] = $urandom_range(0, 7) == 0; hsize[m] = 3'($urandom); hburst[m] = 3'($urandom);
        hprot[m] = 4'($urandom); haddr[m] = $urandom; hwdata[m] = $urandom;
      end
      hsel = 3'($urandom); cs = 3'($urandom); hready = 3'($urandom); hwrite = 3'($urandom);
      sreadyout = $urandom_range(0, 3) != 0; srdata = $urandom; sresp = 1'($urandom);
      if (i == 200) begin
        #2 rst_n = 0;
        #1 chk("async_rst_grant", g, 0); chk("async_rst_hsel", shsel, 0);
      end
    end
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
